fp32_mul_arbiter: RTL and testbench

- Shares one fully pipelined FP32 multiplier (`fp_multiply`-style: `in_valid`, `a`, `b` → `out_valid`, `o`) among NUM_REQ requesters.
- Each cycle, grants at most one request using round-robin arbitration, then registers the operands into the multiplier.
- Carries the winner's ID through a tag pipeline that matches the multiplier latency, and routes each result back to its owner.
- Sits between the force/distance compute units and the single shared multiplier instance.

---
 rtl/fp32_mul_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_fp32_mul_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp32_mul_arbiter                                              |
// | Purpose  : Round-robin front end that shares one fully pipelined FP32    |
// |            multiplier among NUM_REQ requesters. The winner's operands    |
// |            are registered into the multiplier. A tag pipeline of depth   |
// |            MUL_LATENCY carries the winner ID so that each product is     |
// |            routed back to its owner.                                     |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            hold                 - freeze new grants, in-flight ops drain |
// |            req_valid/req_ready  - per-requester handshake (ready comb.)  |
// |            req_a/req_b          - packed operands, 32 bits per requester |
// |            mul_in_valid/a/b     - issue port to the shared multiplier    |
// |            mul_out_valid/mul_o  - result port from the multiplier        |
// |            resp_valid/data/id   - registered one-hot result delivery     |
// |            busy                 - operations in flight                   |
// |            err                  - sticky tag/valid mismatch              |
// |            op_count             - transfer count (stats build only)      |
// | Options  : define FP32_MUL_ARB_STATS_EN to build the saturating op_count |
// |            counter; without it op_count is tied to zero.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fp32_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 3,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   hold,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [32*NUM_REQ-1:0]  req_a,
   input  logic [32*NUM_REQ-1:0]  req_b,
   output logic                   mul_in_valid,
   output logic [31:0]            mul_a,
   output logic [31:0]            mul_b,
   input  logic                   mul_out_valid,
   input  logic [31:0]            mul_o,
   output logic [NUM_REQ-1:0]     resp_valid,
   output logic [31:0]            resp_data,
   output logic [ID_W-1:0]        resp_id,
   output logic                   busy,
   output logic                   err,
   output logic [31:0]            op_count
);

   // Holds up to MUL_LATENCY+2 outstanding ops: issue stage, tag stages, response stage.
   localparam int c_cnt_w = $clog2(MUL_LATENCY + 3);

   logic [ID_W-1:0]                   ptr_q, ptr_d;
   logic                              mul_in_valid_q, mul_in_valid_d;
   logic [31:0]                       mul_a_q, mul_a_d;
   logic [31:0]                       mul_b_q, mul_b_d;
   logic [ID_W-1:0]                   iss_id_q, iss_id_d;
   logic [MUL_LATENCY-1:0]            tag_v_q, tag_v_d;
   logic [MUL_LATENCY-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
   logic [NUM_REQ-1:0]                resp_valid_q, resp_valid_d;
   logic [31:0]                       resp_data_q, resp_data_d;
   logic [ID_W-1:0]                   resp_id_q, resp_id_d;
   logic                              err_q, err_d;
   logic [c_cnt_w-1:0]                cnt_q, cnt_d;

   logic                              xfer;
   logic [ID_W-1:0]                   grant_id;
   logic [31:0]                       grant_a, grant_b;
   logic                              head_v;
   logic [ID_W-1:0]                   head_id;

   // Round-robin search starting at ptr_q and wrapping upward.
   always_comb begin
      int              sum;
      logic [ID_W-1:0] idx;
      xfer      = 1'b0;
      grant_id  = '0;
      grant_a   = '0;
      grant_b   = '0;
      req_ready = '0;
      sum       = 0;
      idx       = '0;
      if (!hold) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= NUM_REQ) begin
               sum = sum - NUM_REQ;
            end
            idx = sum[ID_W-1:0];
            if (!xfer && req_valid[idx]) begin
               xfer     = 1'b1;
               grant_id = idx;
               grant_a  = req_a[{idx, 5'b0} +: 32];
               grant_b  = req_b[{idx, 5'b0} +: 32];
            end
         end
      end
      if (xfer) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   // Issue stage and tag pipeline. Stage 0 of the tag pipeline lines up with
   // the multiplier's first internal stage, so the last stage pairs with
   // mul_out_valid/mul_o.
   always_comb begin
      ptr_d          = ptr_q;
      mul_a_d        = mul_a_q;
      mul_b_d        = mul_b_q;
      iss_id_d       = iss_id_q;
      mul_in_valid_d = xfer;
      if (xfer) begin
         ptr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
         mul_a_d  = grant_a;
         mul_b_d  = grant_b;
         iss_id_d = grant_id;
      end
      tag_v_d     = '0;
      tag_id_d    = '0;
      tag_v_d[0]  = mul_in_valid_q;
      tag_id_d[0] = iss_id_q;
      for (int s = 1; s < MUL_LATENCY; s++) begin
         tag_v_d[s]  = tag_v_q[s-1];
         tag_id_d[s] = tag_id_q[s-1];
      end
   end

   assign head_v  = tag_v_q[MUL_LATENCY-1];
   assign head_id = tag_id_q[MUL_LATENCY-1];

   // Response routing, mismatch detection and in-flight accounting.
   always_comb begin
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;
      err_d        = err_q | (head_v ^ mul_out_valid);
      if (head_v && mul_out_valid) begin
         resp_valid_d[head_id] = 1'b1;
         resp_data_d           = mul_o;
         resp_id_d             = head_id;
      end
      cnt_d = cnt_q;
      if (xfer) begin
         cnt_d = cnt_d + c_cnt_w'(1);
      end
      // An op retires the cycle after its response strobe is visible.
      if (|resp_valid_q) begin
         cnt_d = cnt_d - c_cnt_w'(1);
      end
      // A tagged op whose product never arrived is dropped from the count.
      if (head_v && !mul_out_valid) begin
         cnt_d = cnt_d - c_cnt_w'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q          <= '0;
         mul_in_valid_q <= 1'b0;
         mul_a_q        <= '0;
         mul_b_q        <= '0;
         iss_id_q       <= '0;
         tag_v_q        <= '0;
         tag_id_q       <= '0;
         resp_valid_q   <= '0;
         resp_data_q    <= '0;
         resp_id_q      <= '0;
         err_q          <= 1'b0;
         cnt_q          <= '0;
      end else begin
         ptr_q          <= ptr_d;
         mul_in_valid_q <= mul_in_valid_d;
         mul_a_q        <= mul_a_d;
         mul_b_q        <= mul_b_d;
         iss_id_q       <= iss_id_d;
         tag_v_q        <= tag_v_d;
         tag_id_q       <= tag_id_d;
         resp_valid_q   <= resp_valid_d;
         resp_data_q    <= resp_data_d;
         resp_id_q      <= resp_id_d;
         err_q          <= err_d;
         cnt_q          <= cnt_d;
      end
   end

`ifdef FP32_MUL_ARB_STATS_EN
   logic [31:0] op_count_q, op_count_d;

   always_comb begin
      op_count_d = op_count_q;
      if (xfer && (op_count_q != 32'hFFFF_FFFF)) begin
         op_count_d = op_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q <= '0;
      end else begin
         op_count_q <= op_count_d;
      end
   end

   assign op_count = op_count_q;
`else
   assign op_count = 32'h0;
`endif

   assign mul_in_valid = mul_in_valid_q;
   assign mul_a        = mul_a_q;
   assign mul_b        = mul_b_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_id      = resp_id_q;
   assign err          = err_q;
   assign busy         = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fp32_mul_arbiter                                           |
// | Purpose  : Self-checking bench for fp32_mul_arbiter with a behavioural   |
// |            FP32 multiplier stub and a cycle-level reference model.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fp32_mul_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int MUL_LATENCY = 3;
   localparam int ID_W        = 2;
   localparam int LAT         = MUL_LATENCY + 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  hold = 1'b0;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] req_a = '0;
   logic [32*NUM_REQ-1:0] req_b = '0;
   logic                  mul_in_valid;
   logic [31:0]           mul_a, mul_b;
   logic                  mul_out_valid;
   logic [31:0]           mul_o;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [31:0]           resp_data;
   logic [ID_W-1:0]       resp_id;
   logic                  busy, err;
   logic [31:0]           op_count;

   fp32_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
      .mul_out_valid(mul_out_valid), .mul_o(mul_o),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
      .busy(busy), .err(err), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // FP32 <-> double conversion for normal numbers; product truncated to 23 bits.
   function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] da, db, dp;
      int          e;
      da = {a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'b0};
      db = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'b0};
      dp = $realtobits($bitstoreal(da) * $bitstoreal(db));
      e  = int'(dp[62:52]) - 1023 + 127;
      return {dp[63], e[7:0], dp[51:29]};
   endfunction

   // Shared multiplier stub: fixed latency, deliberately not reset.
   logic        mv_pipe [MUL_LATENCY];
   logic [31:0] mo_pipe [MUL_LATENCY];
   initial begin
      for (int k = 0; k < MUL_LATENCY; k++) begin
         mv_pipe[k] = 1'b0;
         mo_pipe[k] = '0;
      end
   end
   always @(posedge clk) begin
      mv_pipe[0] <= mul_in_valid;
      mo_pipe[0] <= fpmul(mul_a, mul_b);
      for (int k = 1; k < MUL_LATENCY; k++) begin
         mv_pipe[k] <= mv_pipe[k-1];
         mo_pipe[k] <= mo_pipe[k-1];
      end
   end
   assign mul_out_valid = mv_pipe[MUL_LATENCY-1];
   assign mul_o         = mo_pipe[MUL_LATENCY-1];

   typedef struct {
      int          due;
      int          id;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          grant_log[$];
   int          got_id[$];
   int          got_cyc[$];
   logic [31:0] got_data[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          ptr_m    = 0;
   int          ops_m    = 0;
   int          last_acc = -100;
   int          last_g   = -1;
   bit          err_chk  = 1'b1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
   endfunction

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_valid[i]       = 1'b1;
      req_a[32*i +: 32]  = a;
      req_b[32*i +: 32]  = b;
   endtask

   // One clock cycle: check DUT against the model at negedge, advance the model.
   task automatic step();
      int                 g;
      exp_t               e;
      logic [NUM_REQ-1:0] er;
      @(negedge clk);
      g = -1;
      if (!hold) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (ptr_m + k) % NUM_REQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(er));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e  = exp_q.pop_front();
         er = '0;
         er[e.id] = 1'b1;
         check("resp_valid", 64'(resp_valid), 64'(er));
         check("resp_id", 64'(resp_id), 64'(e.id));
         check("resp_data", 64'(resp_data), 64'(e.data));
      end else begin
         check("resp_valid_idle", 64'(resp_valid), 64'(0));
      end
      if (resp_valid != '0) begin
         got_data.push_back(resp_data);
         got_id.push_back(int'(resp_id));
         got_cyc.push_back(cyc);
      end
      check("busy", 64'(busy), 64'(last_acc + LAT >= cyc));
`ifdef FP32_MUL_ARB_STATS_EN
      check("op_count", 64'(op_count), 64'(ops_m));
`else
      check("op_count", 64'(op_count), 64'(0));
`endif
      if (err_chk) check("err", 64'(err), 64'(0));
      last_g = g;
      if (g >= 0) begin
         e.due  = cyc + LAT;
         e.id   = g;
         e.data = fpmul(req_a[32*g +: 32], req_b[32*g +: 32]);
         exp_q.push_back(e);
         ptr_m    = (g + 1) % NUM_REQ;
         ops_m    = ops_m + 1;
         last_acc = cyc;
         grant_log.push_back(g);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      got_id.delete();
      got_data.delete();
      got_cyc.delete();
   endtask

   task automatic model_reset();
      exp_q.delete();
      ptr_m    = 0;
      ops_m    = 0;
      last_acc = -100;
   endtask

   task automatic check_zero_outputs(input string pfx);
      check({pfx, "_mul_in_valid"}, 64'(mul_in_valid), 64'(0));
      check({pfx, "_mul_a"}, 64'(mul_a), 64'(0));
      check({pfx, "_mul_b"}, 64'(mul_b), 64'(0));
      check({pfx, "_resp_valid"}, 64'(resp_valid), 64'(0));
      check({pfx, "_resp_data"}, 64'(resp_data), 64'(0));
      check({pfx, "_resp_id"}, 64'(resp_id), 64'(0));
      check({pfx, "_busy"}, 64'(busy), 64'(0));
      check({pfx, "_err"}, 64'(err), 64'(0));
      check({pfx, "_op_count"}, 64'(op_count), 64'(0));
   endtask

   initial begin
      int acc_cyc;
      // ---------------- initial reset ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // ---------------- round-robin, all requesters valid ----------------
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_fp(), rand_fp());
      for (int n = 0; n < 8; n++) begin
         step();
         if (last_g >= 0) set_req(last_g, rand_fp(), rand_fp());
      end
      req_valid = '0;
      repeat (LAT + 2) step();
      check("rr_grants", 64'(grant_log.size()), 64'(8));
      check("rr_results", 64'(got_id.size()), 64'(8));
      for (int k = 0; k < 8 && k < grant_log.size() && k < got_id.size(); k++) begin
         check("rr_order", 64'(grant_log[k]), 64'(k % NUM_REQ));
         check("rr_resp_id", 64'(got_id[k]), 64'(k % NUM_REQ));
      end

      // ---------------- single op: 2.0 * 3.0 ----------------
      clear_logs();
      set_req(0, 32'h4000_0000, 32'h4040_0000);
      acc_cyc = cyc;
      step();
      req_valid = '0;
      repeat (LAT + 2) step();
      check("single_count", 64'(got_data.size()), 64'(1));
      if (got_data.size() > 0) begin
         check("single_data", 64'(got_data[0]), 64'(32'h40C0_0000));
         check("single_id", 64'(got_id[0]), 64'(0));
         check("single_latency", 64'(got_cyc[0] - acc_cyc), 64'(5));
      end

      // ---------------- distinct results, req1 then req3 ----------------
      clear_logs();
      set_req(1, 32'h3FC0_0000, 32'hC000_0000);
      set_req(3, 32'h3F00_0000, 32'h3F00_0000);
      step();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
      step();
      req_valid = '0;
      repeat (LAT + 2) step();
      check("distinct_count", 64'(got_data.size()), 64'(2));
      if (got_data.size() == 2) begin
         check("distinct_id0", 64'(got_id[0]), 64'(1));
         check("distinct_data0", 64'(got_data[0]), 64'(32'hC040_0000));
         check("distinct_id1", 64'(got_id[1]), 64'(3));
         check("distinct_data1", 64'(got_data[1]), 64'(32'h3E80_0000));
         check("distinct_b2b", 64'(got_cyc[1] - got_cyc[0]), 64'(1));
      end

      // ---------------- hold with two ops in flight ----------------
      clear_logs();
      set_req(0, rand_fp(), rand_fp());
      set_req(1, rand_fp(), rand_fp());
      repeat (2) begin
         step();
         if (last_g >= 0) req_valid[last_g] = 1'b0;
      end
      hold = 1'b1;
      set_req(2, rand_fp(), rand_fp());
      repeat (3) begin
         #2 check("hold_ready", 64'(req_ready), 64'(0));
         step();
      end
      hold = 1'b0;
      step();
      req_valid = '0;
      check("hold_resume_grant", 64'(grant_log[grant_log.size()-1]), 64'(2));
      repeat (LAT + 2) step();
      check("hold_results", 64'(got_id.size()), 64'(3));

      // ---------------- reset with three ops in flight ----------------
      set_req(0, rand_fp(), rand_fp());
      set_req(1, rand_fp(), rand_fp());
      set_req(3, rand_fp(), rand_fp());
      repeat (3) begin
         step();
         if (last_g >= 0) req_valid[last_g] = 1'b0;
      end
      check("pre_reset_busy", 64'(busy), 64'(1));
      req_valid = '0;
      #1 rst_n = 1'b0;
      #1 check_zero_outputs("midreset");
      #1 rst_n = 1'b1;
      model_reset();
      err_chk = 1'b0;
      clear_logs();
      repeat (LAT + 4) step();
      check("stale_no_resp", 64'(got_id.size()), 64'(0));
      check("stale_err", 64'(err), 64'(1));

      // ---------------- clean reset, stats ----------------
      rst_n = 1'b0;
      repeat (MUL_LATENCY + 3) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = cyc + MUL_LATENCY + 3;
      model_reset();
      check("clean_err", 64'(err), 64'(0));
      err_chk = 1'b1;
      for (int n = 0; n < 10; n++) begin
         set_req(0, rand_fp(), rand_fp());
         step();
      end
      req_valid = '0;
      repeat (LAT + 2) step();
`ifdef FP32_MUL_ARB_STATS_EN
      check("stats_10", 64'(op_count), 64'(10));
`else
      check("stats_off", 64'(op_count), 64'(0));
`endif

      // ---------------- randomized traffic ----------------
      for (int n = 0; n < 400; n++) begin
         step();
         if (last_g >= 0) req_valid[last_g] = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 99) < 45) set_req(i, rand_fp(), rand_fp());
         end
         hold = ($urandom_range(0, 9) == 0);
      end
      hold      = 1'b0;
      req_valid = '0;
      repeat (LAT + 3) step();
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      check("final_busy", 64'(busy), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
